census_win: RTL



---
 rtl/census_win.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/census_win.sv
// Streaming census transform: line-buffered WIN_H x WIN_W window over a raster
// grey stream, thresholded census code per in-frame centre, two-stage pipeline.
module census_win #(
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 240,
  parameter int unsigned WIN_H        = 7,
  parameter int unsigned WIN_W        = 9,
  parameter int unsigned PIX_W        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic [PIX_W-1:0]           in_pix,
  input  logic [PIX_W-1:0]           cfg_thresh,
  output logic                       out_valid,
  output logic [WIN_H*WIN_W-2:0]     out_census,
  output logic [15:0]                out_row,
  output logic [15:0]                out_col,
  output logic                       out_eof
);

  localparam int unsigned RH     = (WIN_H - 1) / 2;
  localparam int unsigned RW     = (WIN_W - 1) / 2;
  localparam int unsigned CODE_W = WIN_H * WIN_W - 1;
  localparam int unsigned NLB    = WIN_H - 1;
  localparam int unsigned AW     = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned CTR    = RH * WIN_W + RW;

  logic [15:0]       row_q, col_q, row_d, col_d;
  logic [15:0]       row_cur, col_cur;
  logic [AW-1:0]     lb_addr;
  logic [PIX_W-1:0]  lb_mem [NLB][IMAGE_WIDTH];
  logic [PIX_W-1:0]  col_in [WIN_H];
  logic [PIX_W-1:0]  win_q  [WIN_H][WIN_W];
  logic              complete, at_last;

  logic              v1_q, eof1_q;
  logic [15:0]       row1_q, col1_q;
  logic [PIX_W-1:0]  thr1_q;
  logic [CODE_W-1:0] code;

  // Position of the current beat and of the next one.
  always_comb begin
    row_cur = in_sof ? 16'd0 : row_q;
    col_cur = in_sof ? 16'd0 : col_q;
    row_d   = row_q;
    col_d   = col_q;
    if (in_valid) begin
      if (col_cur == 16'(IMAGE_WIDTH - 1)) begin
        col_d = 16'd0;
        row_d = (row_cur == 16'(IMAGE_HEIGHT - 1)) ? 16'd0 : row_cur + 16'd1;
      end else begin
        col_d = col_cur + 16'd1;
        row_d = row_cur;
      end
    end
  end

  assign lb_addr  = AW'(col_cur);
  assign complete = in_valid && (row_cur >= 16'(WIN_H - 1)) && (col_cur >= 16'(WIN_W - 1));
  assign at_last  = (row_cur == 16'(IMAGE_HEIGHT - 1)) && (col_cur == 16'(IMAGE_WIDTH - 1));

  always_comb begin
    col_in[0] = in_pix;
    for (int j = 1; j < int'(WIN_H); j++) begin
      col_in[j] = lb_mem[j-1][lb_addr];
    end
  end

  // Line buffers cascade at the column address: each read feeds the next line's write.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb_mem[0][lb_addr] <= in_pix;
      for (int k = 1; k < int'(NLB); k++) begin
        lb_mem[k][lb_addr] <= lb_mem[k-1][lb_addr];
      end
    end
  end

  // S1: position counters, window shift, tag capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= 16'd0;
      col_q  <= 16'd0;
      v1_q   <= 1'b0;
      eof1_q <= 1'b0;
      row1_q <= 16'd0;
      col1_q <= 16'd0;
      thr1_q <= '0;
      for (int j = 0; j < int'(WIN_H); j++) begin
        for (int i = 0; i < int'(WIN_W); i++) begin
          win_q[j][i] <= '0;
        end
      end
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      v1_q  <= complete;
      if (in_valid) begin
        thr1_q <= cfg_thresh;
        row1_q <= row_cur - 16'(RH);
        col1_q <= col_cur - 16'(RW);
        eof1_q <= at_last;
        for (int j = 0; j < int'(WIN_H); j++) begin
          win_q[j][0] <= col_in[j];
          for (int i = 1; i < int'(WIN_W); i++) begin
            win_q[j][i] <= win_q[j][i-1];
          end
        end
      end
    end
  end

  // Row 0 / column 0 of win_q is the newest, so raster index t maps to the mirrored cell.
  for (genvar t = 0; t < int'(WIN_H * WIN_W); t++) begin : g_bit
    if (t != int'(CTR)) begin : g_cmp
      localparam int unsigned J = WIN_H - 1 - t / WIN_W;
      localparam int unsigned I = WIN_W - 1 - t % WIN_W;
      localparam int unsigned B = (t < int'(CTR)) ? CODE_W - 1 - t : CODE_W - t;
      assign code[B] = ({1'b0, win_q[J][I]} + {1'b0, thr1_q}) < {1'b0, win_q[RH][RW]};
    end
  end

  // S2: registered outputs, held while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_eof    <= 1'b0;
      out_census <= '0;
      out_row    <= 16'd0;
      out_col    <= 16'd0;
    end else begin
      out_valid <= v1_q;
      out_eof   <= v1_q & eof1_q;
      if (v1_q) begin
        out_census <= code;
        out_row    <= row1_q;
        out_col    <= col1_q;
      end
    end
  end

endmodule
